// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the four-digit BCD scanner: digit geometry and
// active-low seven-segment codes ordered {g,f,e,d,c,b,a}.
package bcd_display_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned WORD_W     = NUM_DIGITS * DIGIT_W;

    localparam logic [DIGIT_W-1:0] MAX_BCD = DIGIT_W'(9);

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // True when any nibble of the word is not a legal BCD digit.
    function automatic logic any_invalid(input logic [WORD_W-1:0] word);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (word[i*DIGIT_W +: DIGIT_W] > MAX_BCD) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_display_scan_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD values
// show a dash, and the blank flag overrides everything.
module bcd_to_seg7
    import bcd_display_scan_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               blank,
    output logic [6:0]         seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed four-digit BCD display driver with optional leading-zero
// blanking and an invalid-digit flag; an and seg are registered together.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 4,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_W-1:0]     bcd_in,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  err
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]                   cnt;
    logic [IDX_W-1:0]                   idx;
    logic [IDX_W-1:0]                   idx_next;
    logic                               cnt_wrap;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;
    logic [WORD_W-1:0]                  digit_word;
    logic [DIGIT_W-1:0]                 sel_digit;
    logic                               sel_blank;
    logic [NUM_DIGITS-1:0]              an_next;
    seg_t                               seg_next;

    // an/seg are built from the index the register is about to hold, so the
    // enable and its segment pattern both switch on the advance edge.
    always_comb begin
        cnt_wrap   = (cnt == CNT_LAST);
        idx_next   = cnt_wrap ? idx + 1'b1 : idx;
        digit_word = digits;
        sel_digit  = digits[idx_next];
        an_next    = ~(NUM_DIGITS'(1) << idx_next);
        sel_blank  = 1'b0;
        // Blank when this digit and every higher one is zero; digit0 always lit.
        if (BLANK_LZ && (idx_next != '0)) begin
            sel_blank = ((digit_word >> (DIGIT_W * idx_next)) == '0);
        end
    end

    bcd_to_seg7 u_dec (
        .digit (sel_digit),
        .blank (sel_blank),
        .seg   (seg_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            digits <= '0;
            err    <= 1'b0;
            an     <= ~NUM_DIGITS'(1);
            seg    <= SEG_0;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            idx <= idx_next;
            an  <= an_next;
            seg <= seg_next;
            if (load) begin
                digits <= bcd_in;
                err    <= any_invalid(bcd_in);
            end
        end
    end

endmodule
